// File: rtl/data_sync_hs.sv
// Multi-bit CDC synchronizer: BUS_EN is synchronized, the bus is captured once it reads
// stable for two consecutive cycles, and a four-phase ACK handshake is returned to the source.
module data_sync_hs #(
    parameter int NUM_STAGES = 2,
    parameter int BUS_WIDTH  = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
    input  logic                 BUS_EN,
    output logic [BUS_WIDTH-1:0] SYNC_BUS,
    output logic                 ENABLE_PULSE,
    output logic                 ACK,
    output logic                 STABLE_ERR,
    output logic [7:0]           CAPTURE_CNT
);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t                 state, state_nxt;
    logic [NUM_STAGES-1:0]  sync_p;
    logic                   en_s;
    logic [BUS_WIDTH-1:0]   shadow, shadow_nxt;
    logic [BUS_WIDTH-1:0]   sync_bus_nxt;
    logic                   pulse_nxt;
    logic                   ack_nxt;
    logic                   err_nxt;
    logic [7:0]             cnt_nxt;

    // Stage p0..pN: BUS_EN synchronizer chain; nothing else looks at BUS_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[NUM_STAGES-2:0], BUS_EN};
        end
    end

    assign en_s = sync_p[NUM_STAGES-1];

    // Next-state and next-output decode; every output is registered below
    always_comb begin
        state_nxt    = state;
        shadow_nxt   = shadow;
        sync_bus_nxt = SYNC_BUS;
        pulse_nxt    = 1'b0;
        ack_nxt      = ACK;
        err_nxt      = STABLE_ERR;
        cnt_nxt      = CAPTURE_CNT;

        case (state)
            IDLE: begin
                ack_nxt = 1'b0;
                if (en_s) begin
                    shadow_nxt = UNSYNC_BUS;
                    state_nxt  = WAIT;
                end
            end
            WAIT: begin
                if (!en_s) begin
                    state_nxt = IDLE;
                end else if (UNSYNC_BUS == shadow) begin
                    sync_bus_nxt = shadow;
                    pulse_nxt    = 1'b1;
                    ack_nxt      = 1'b1;
                    cnt_nxt      = CAPTURE_CNT + 8'd1;
                    state_nxt    = HOLD;
                end else begin
                    // Bus moved since the last sample: resample and retry next cycle
                    shadow_nxt = UNSYNC_BUS;
                    err_nxt    = 1'b1;
                end
            end
            HOLD: begin
                if (!en_s) begin
                    ack_nxt   = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    ack_nxt = 1'b1;
                end
            end
            default: begin
                ack_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Output stage: state, shadow and all outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            shadow       <= '0;
            SYNC_BUS     <= '0;
            ENABLE_PULSE <= 1'b0;
            ACK          <= 1'b0;
            STABLE_ERR   <= 1'b0;
            CAPTURE_CNT  <= 8'd0;
        end else begin
            state        <= state_nxt;
            shadow       <= shadow_nxt;
            SYNC_BUS     <= sync_bus_nxt;
            ENABLE_PULSE <= pulse_nxt;
            ACK          <= ack_nxt;
            STABLE_ERR   <= err_nxt;
            CAPTURE_CNT  <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_data_sync_hs.sv
// Directed bench for data_sync_hs: handshake latency, ACK release, unstable bus,
// aborted request, mid-handshake reset and capture counter wrap.
module tb_data_sync_hs;

  logic       CLK;
  logic       RST;
  logic [7:0] UNSYNC_BUS;
  logic       BUS_EN;
  logic [7:0] SYNC_BUS;
  logic       ENABLE_PULSE;
  logic       ACK;
  logic       STABLE_ERR;
  logic [7:0] CAPTURE_CNT;

  int n_vec = 0;
  int n_err = 0;
  int pulses;

  data_sync_hs #(
    .NUM_STAGES (2),
    .BUS_WIDTH  (8)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .UNSYNC_BUS   (UNSYNC_BUS),
    .BUS_EN       (BUS_EN),
    .SYNC_BUS     (SYNC_BUS),
    .ENABLE_PULSE (ENABLE_PULSE),
    .ACK          (ACK),
    .STABLE_ERR   (STABLE_ERR),
    .CAPTURE_CNT  (CAPTURE_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one rising edge and settle 1 ns past it
  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST        = 1'b0;
    BUS_EN     = 1'b0;
    UNSYNC_BUS = 8'h00;
    step;
    step;
    chk("rst_sync_bus", SYNC_BUS, 8'h00);
    chk("rst_pulse", ENABLE_PULSE, 1'b0);
    chk("rst_ack", ACK, 1'b0);
    chk("rst_err", STABLE_ERR, 1'b0);
    chk("rst_cnt", CAPTURE_CNT, 8'd0);
    RST = 1'b1;

    // First capture: 0xA5, request raised before edge 0
    UNSYNC_BUS = 8'hA5;
    BUS_EN     = 1'b1;
    step; step; step;
    chk("a5_e2_pulse", ENABLE_PULSE, 1'b0);
    chk("a5_e2_ack", ACK, 1'b0);
    step;
    chk("a5_e3_pulse", ENABLE_PULSE, 1'b1);
    chk("a5_e3_sync", SYNC_BUS, 8'hA5);
    chk("a5_e3_ack", ACK, 1'b1);
    chk("a5_e3_cnt", CAPTURE_CNT, 8'd1);
    step;
    chk("a5_e4_pulse", ENABLE_PULSE, 1'b0);
    chk("a5_e4_ack", ACK, 1'b1);
    repeat (5) step;
    BUS_EN = 1'b0;
    step; step;
    chk("a5_e11_ack", ACK, 1'b1);
    step;
    chk("a5_e12_ack", ACK, 1'b0);
    chk("a5_e12_sync", SYNC_BUS, 8'hA5);

    // Second request: 0x3C
    UNSYNC_BUS = 8'h3C;
    BUS_EN     = 1'b1;
    step; step; step; step;
    chk("3c_pulse", ENABLE_PULSE, 1'b1);
    chk("3c_sync", SYNC_BUS, 8'h3C);
    chk("3c_cnt", CAPTURE_CNT, 8'd2);
    chk("3c_err", STABLE_ERR, 1'b0);
    BUS_EN = 1'b0;
    step; step; step;
    chk("3c_ack_rel", ACK, 1'b0);

    // One-cycle request: reaches WAIT but en_s is already low at the compare
    UNSYNC_BUS = 8'h77;
    BUS_EN     = 1'b1;
    step;
    BUS_EN = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step;
      if (ENABLE_PULSE) pulses++;
      chk("abort_ack", ACK, 1'b0);
    end
    chk("abort_pulses", pulses, 0);
    chk("abort_sync", SYNC_BUS, 8'h3C);
    chk("abort_cnt", CAPTURE_CNT, 8'd2);

    // Bus changes 0x11 -> 0x22 as the FSM enters WAIT
    UNSYNC_BUS = 8'h11;
    BUS_EN     = 1'b1;
    step; step; step;
    UNSYNC_BUS = 8'h22;
    step;
    chk("unst_e3_pulse", ENABLE_PULSE, 1'b0);
    chk("unst_e3_err", STABLE_ERR, 1'b1);
    chk("unst_e3_ack", ACK, 1'b0);
    step;
    chk("unst_e4_pulse", ENABLE_PULSE, 1'b1);
    chk("unst_e4_sync", SYNC_BUS, 8'h22);
    chk("unst_e4_cnt", CAPTURE_CNT, 8'd3);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step;
      if (ENABLE_PULSE) pulses++;
    end
    chk("unst_hold_pulses", pulses, 0);
    chk("unst_hold_ack", ACK, 1'b1);
    chk("unst_err_sticky", STABLE_ERR, 1'b1);

    // Reset while in HOLD with BUS_EN still high
    RST = 1'b0;
    #1;
    chk("midrst_sync", SYNC_BUS, 8'h00);
    chk("midrst_pulse", ENABLE_PULSE, 1'b0);
    chk("midrst_ack", ACK, 1'b0);
    chk("midrst_err", STABLE_ERR, 1'b0);
    chk("midrst_cnt", CAPTURE_CNT, 8'd0);
    step;
    RST = 1'b1;
    step; step; step;
    chk("rerun_e2_pulse", ENABLE_PULSE, 1'b0);
    step;
    chk("rerun_e3_pulse", ENABLE_PULSE, 1'b1);
    chk("rerun_e3_sync", SYNC_BUS, 8'h22);
    chk("rerun_e3_cnt", CAPTURE_CNT, 8'd1);
    chk("rerun_e3_ack", ACK, 1'b1);
    BUS_EN = 1'b0;
    step; step; step;
    chk("rerun_ack_rel", ACK, 1'b0);

    // 256 full handshakes from a cleared counter
    RST = 1'b0;
    #1;
    chk("wrap_start_cnt", CAPTURE_CNT, 8'd0);
    RST    = 1'b1;
    pulses = 0;
    for (int h = 0; h < 256; h++) begin
      UNSYNC_BUS = 8'(h);
      BUS_EN     = 1'b1;
      repeat (4) begin
        step;
        if (ENABLE_PULSE) pulses++;
      end
      BUS_EN = 1'b0;
      repeat (3) begin
        step;
        if (ENABLE_PULSE) pulses++;
      end
    end
    chk("wrap_cnt", CAPTURE_CNT, 8'd0);
    chk("wrap_pulses", pulses, 256);
    chk("wrap_sync", SYNC_BUS, 8'hFF);
    chk("wrap_ack", ACK, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
